// File: rtl/cim_pkg.sv
// cim_pkg: shared address map, register offsets, CTRL/STATUS bit indices and FSM states
// for the CIM int8 dot-product engine.
package cim_pkg;
   localparam logic [31:0] CIM_BASE_ADDR = 32'h0800_0000;
   localparam logic [31:0] CIM_WORD_BASE = CIM_BASE_ADDR >> 2;
   localparam logic [9:0]  OFF_CTRL   = 10'h000;
   localparam logic [9:0]  OFF_STATUS = 10'h001;
   localparam logic [9:0]  OFF_LEN    = 10'h002;
   localparam logic [9:0]  OFF_RESULT = 10'h003;
   localparam logic [1:0]  REGION_A   = 2'b01;
   localparam logic [1:0]  REGION_B   = 2'b10;
   localparam int CTRL_START = 0;
   localparam int CTRL_CLR   = 1;
   localparam int CTRL_ACC   = 2;
   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_OVF   = 2;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/cim_dot4.sv
// cim_dot4: combinational dot product of four signed int8 lanes, 18-bit signed result.
module cim_dot4 (
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   output logic signed [17:0] dot
);
   logic signed [15:0] p [4];
   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic signed [15:0] sa, sb;
      assign sa = {{8{a[8*k+7]}}, a[8*k+:8]};
      assign sb = {{8{b[8*k+7]}}, b[8*k+:8]};
      assign p[k] = sa * sb;
   end
   assign dot = {{2{p[0][15]}}, p[0]} + {{2{p[1][15]}}, p[1]}
              + {{2{p[2][15]}}, p[2]} + {{2{p[3][15]}}, p[3]};
endmodule

// File: rtl/cim_mac_unit.sv
// cim_mac_unit: memory-mapped int8 dot-product engine with stall on busy RESULT reads.
// Define CIM_SATURATE_EN for a saturating accumulator with sticky OVF; otherwise it wraps.
module cim_mac_unit
   import cim_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic [31:0] DADDR,
   input  logic [31:0] DATAO,
   input  logic [3:0]  BE,
   input  logic        WR,
   input  logic        RD,
   output logic [31:0] DATAI,
   output logic        HLT,
   output logic        IRQ
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   state_e state_q, state_d;
   logic start_q, start_d, done_q, done_d, ovf_q, ovf_d;
   logic [8:0] len_q, len_d;
   logic [31:0] res_q, res_d;
   logic [IW-1:0] idx_q, idx_d;
   logic signed [17:0] prod_q, prod_d, dot;
   logic [31:0] a_mem [DEPTH];
   logic [31:0] b_mem [DEPTH];
   logic [9:0] off;
   logic sel, we, busy, reg_wr, ctrl_wr, in_a, in_b, last, sat_ovf;
   logic [31:0] sum, acc_next, status;
   assign off = DADDR[9:0];
   assign sel = DADDR[31:10] == CIM_WORD_BASE[31:10];
   assign we = sel && WR;
   assign busy = start_q || (state_q != IDLE);
   assign reg_wr = we && !busy;
   assign ctrl_wr = we && (off == OFF_CTRL);
   assign in_a = (off[9:8] == REGION_A) && ({1'b0, off[7:0]} < 9'(DEPTH));
   assign in_b = (off[9:8] == REGION_B) && ({1'b0, off[7:0]} < 9'(DEPTH));
   assign last = (9'(idx_q) + 9'd1) == len_q;
   assign sum = res_q + {{14{prod_q[17]}}, prod_q};
`ifdef CIM_SATURATE_EN
   assign sat_ovf = (res_q[31] == prod_q[17]) && (sum[31] != res_q[31]);
   assign acc_next = sat_ovf ? (res_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`else
   assign sat_ovf = 1'b0;
   assign acc_next = sum;
`endif
   assign HLT = sel && RD && (off == OFF_RESULT) && busy;
   assign IRQ = state_q == DRAIN;
   cim_dot4 u_dot4 (
      .a   (a_mem[idx_q]),
      .b   (b_mem[idx_q]),
      .dot (dot)
   );
   always_comb begin
      status = '0;
      status[STAT_BUSY] = busy;
      status[STAT_DONE] = done_q;
      status[STAT_OVF]  = ovf_q;
      DATAI = !sel                ? '0 :
              off == OFF_STATUS   ? status :
              off == OFF_LEN      ? {23'd0, len_q} :
              off == OFF_RESULT   ? res_q :
              in_a                ? a_mem[off[IW-1:0]] :
              in_b                ? b_mem[off[IW-1:0]] : '0;
   end
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      done_d  = done_q;
      ovf_d   = ovf_q;
      len_d   = len_q;
      res_d   = res_q;
      idx_d   = idx_q;
      prod_d  = prod_q;
      if (reg_wr && off == OFF_LEN)
         len_d = (DATAO[8:0] > 9'(DEPTH)) ? 9'(DEPTH) : DATAO[8:0];
      if (reg_wr && off == OFF_RESULT)
         res_d = DATAO;
      if (reg_wr && off == OFF_CTRL && DATAO[CTRL_START]) begin
         start_d = 1'b1;
         done_d  = 1'b0;
         ovf_d   = 1'b0;
         res_d   = DATAO[CTRL_ACC] ? res_q : '0;
      end
      // a zero-length run drains a zero product so DONE/IRQ timing matches every other run
      if (start_q) begin
         state_d = (len_q == 9'd0) ? DRAIN : RUN;
         idx_d   = '0;
         prod_d  = '0;
      end else if (state_q == RUN) begin
         prod_d  = dot;
         res_d   = acc_next;
         ovf_d   = ovf_q || sat_ovf;
         idx_d   = idx_q + 1'b1;
         state_d = last ? DRAIN : RUN;
      end else if (state_q == DRAIN) begin
         res_d   = acc_next;
         ovf_d   = ovf_q || sat_ovf;
         done_d  = 1'b1;
         state_d = IDLE;
      end
      if (ctrl_wr && DATAO[CTRL_CLR]) begin
         state_d = IDLE;
         start_d = 1'b0;
         done_d  = 1'b0;
         ovf_d   = 1'b0;
         res_d   = '0;
      end
   end
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         len_q   <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         len_q   <= len_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
         prod_q  <= prod_d;
      end
   end
   always_ff @(posedge CLK) begin
      for (int k = 0; k < 4; k++) begin
         if (reg_wr && in_a && BE[k]) a_mem[off[IW-1:0]][8*k+:8] <= DATAO[8*k+:8];
         if (reg_wr && in_b && BE[k]) b_mem[off[IW-1:0]][8*k+:8] <= DATAO[8*k+:8];
      end
   end
endmodule

// File: tb/tb_cim_mac_unit.sv
// tb_cim_mac_unit: directed table of single-word runs plus hand-written stall, ignore,
// abort and reset sequences for cim_mac_unit.
module tb_cim_mac_unit;
   localparam logic [31:0] WBASE = 32'h0200_0000;
   localparam logic [9:0] O_CTRL = 10'h000, O_STAT = 10'h001, O_LEN = 10'h002, O_RES = 10'h003;
   localparam logic [9:0] O_A = 10'h100, O_B = 10'h200;
   logic CLK = 1'b0, RES = 1'b0, WR = 1'b0, RD = 1'b0, HLT, IRQ;
   logic [31:0] DADDR = '0, DATAO = '0, DATAI;
   logic [3:0] BE = '0;
   int checks = 0, errors = 0, irq_cnt = 0;
   cim_mac_unit dut (
      .CLK(CLK), .RES(RES), .DADDR(DADDR), .DATAO(DATAO), .BE(BE),
      .WR(WR), .RD(RD), .DATAI(DATAI), .HLT(HLT), .IRQ(IRQ)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) if (IRQ === 1'b1) irq_cnt++;
   typedef struct packed {
      logic [31:0] a, b, init;
      logic [8:0]  len;
      logic        acc;
      logic [31:0] exp;
      logic        ovf;
   } vec_t;
   vec_t v [8];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wrb(input logic [9:0] o, input logic [31:0] d, input logic [3:0] be);
      @(negedge CLK);
      DADDR = WBASE | 32'(o); DATAO = d; BE = be; WR = 1'b1;
      @(posedge CLK);
      #1 WR = 1'b0; BE = '0; DADDR = '0; DATAO = '0;
   endtask
   task automatic wr(input logic [9:0] o, input logic [31:0] d);
      wrb(o, d, 4'hF);
   endtask
   task automatic rd_raw(input logic [31:0] addr, output logic [31:0] d);
      @(negedge CLK);
      DADDR = addr; RD = 1'b1;
      #1 d = DATAI;
      RD = 1'b0; DADDR = '0;
   endtask
   task automatic rd(input logic [9:0] o, output logic [31:0] d);
      rd_raw(WBASE | 32'(o), d);
   endtask
   task automatic wait_done(output int edges);
      logic [31:0] s;
      edges = 0;
      s = '0;
      while (!s[1] && edges < 40) begin
         @(posedge CLK);
         edges++;
         rd(O_STAT, s);
      end
   endtask
   initial begin
      logic [31:0] d;
      int e, n0, hcnt;
      v[0] = '{32'h01020304, 32'h01010101, 32'h0, 9'd1, 1'b0, 32'd10, 1'b0};
      v[1] = '{32'h80808080, 32'h7F7F7F7F, 32'h5, 9'd1, 1'b0, 32'hFFFF0200, 1'b0};
      v[2] = '{32'h80808080, 32'h80808080, 32'h0, 9'd1, 1'b0, 32'h00010000, 1'b0};
      v[3] = '{32'hFFFFFFFF, 32'h02030405, 32'd123, 9'd1, 1'b0, 32'hFFFFFFF2, 1'b0};
`ifdef CIM_SATURATE_EN
      v[4] = '{32'h01010101, 32'h0A0A0A0A, 32'h7FFFFFF0, 9'd1, 1'b1, 32'h7FFFFFFF, 1'b1};
`else
      v[4] = '{32'h01010101, 32'h0A0A0A0A, 32'h7FFFFFF0, 9'd1, 1'b1, 32'h80000018, 1'b0};
`endif
      v[5] = '{32'h0, 32'h0, 32'h55, 9'd0, 1'b1, 32'h55, 1'b0};
      v[6] = '{32'h0, 32'h0, 32'h55, 9'd0, 1'b0, 32'h0, 1'b0};
      v[7] = '{32'h01020304, 32'hFFFFFFFF, 32'd100, 9'd1, 1'b1, 32'd90, 1'b0};
      #1;
      chk("rst_datai", DATAI, 0);
      chk("rst_hlt", 32'(HLT), 0);
      chk("rst_irq", 32'(IRQ), 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) RES = 1'b1;
      rd(O_STAT, d); chk("rst_status", d, 0);
      rd(O_LEN, d);  chk("rst_len", d, 0);
      rd(O_RES, d);  chk("rst_result", d, 0);
      wr(O_A, 32'h11223344);
      wrb(O_A, 32'hAABBCCDD, 4'b0101);
      rd(O_A, d); chk("byte_enable", d, 32'h11BB33DD);
      rd(10'h004, d); chk("unmapped_004", d, 0);
      rd(10'h300, d); chk("unmapped_300", d, 0);
      rd_raw(32'h0000_0103, d); chk("not_selected", d, 0);
      wr(O_LEN, 32'd300);
      rd(O_LEN, d); chk("len_clamp", d, 32'd256);
      for (int i = 0; i < 8; i++) begin
         wr(O_RES, v[i].init);
         wr(O_A, v[i].a);
         wr(O_B, v[i].b);
         wr(O_LEN, 32'(v[i].len));
         n0 = irq_cnt;
         wr(O_CTRL, {29'd0, v[i].acc, 2'b01});
         wait_done(e);
         chk($sformatf("v%0d_latency", i), e, 32'(v[i].len) + 2);
         rd(O_RES, d);  chk($sformatf("v%0d_result", i), d, v[i].exp);
         rd(O_STAT, d); chk($sformatf("v%0d_status", i), d, {29'd0, v[i].ovf, 2'b10});
         chk($sformatf("v%0d_irq", i), irq_cnt - n0, 1);
      end
      for (int i = 0; i < 8; i++) begin
         wr(O_A + 10'(i), {4{8'(i + 1)}});
         wr(O_B + 10'(i), 32'h01010101);
      end
      wr(O_LEN, 32'd4);
      wr(O_CTRL, 32'h1);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      DADDR = WBASE | 32'(O_RES); RD = 1'b1;
      #1 hcnt = 0;
      for (int k = 0; k < 20 && HLT; k++) begin
         hcnt++;
         @(negedge CLK);
         #1;
      end
      chk("stall_cycles", hcnt, 4);
      chk("stall_data", DATAI, 32'd40);
      RD = 1'b0; DADDR = '0;
      rd(O_STAT, d); chk("stall_status", d, 32'h2);
      wr(O_LEN, 32'd8);
      n0 = irq_cnt;
      wr(O_CTRL, 32'h1);
      wr(O_A, 32'h7F7F7F7F);
      wr(O_LEN, 32'd1);
      wr(O_RES, 32'hDEAD);
      wr(O_CTRL, 32'h1);
      wait_done(e);
      rd(O_RES, d);  chk("busy_result", d, 32'd144);
      rd(O_LEN, d);  chk("busy_len", d, 32'd8);
      rd(O_A, d);    chk("busy_a0", d, 32'h01010101);
      rd(O_STAT, d); chk("busy_status", d, 32'h2);
      chk("busy_irq", irq_cnt - n0, 1);
      n0 = irq_cnt;
      wr(O_CTRL, 32'h1);
      repeat (2) @(posedge CLK);
      wr(O_CTRL, 32'h2);
      rd(O_STAT, d); chk("clr_status", d, 0);
      rd(O_RES, d);  chk("clr_result", d, 0);
      repeat (12) @(posedge CLK);
      chk("clr_irq", irq_cnt - n0, 0);
      rd(O_STAT, d); chk("clr_status_late", d, 0);
      wr(O_RES, 32'd77);
      wr(O_CTRL, 32'h3);
      rd(O_STAT, d); chk("clr_start_status", d, 0);
      rd(O_RES, d);  chk("clr_start_result", d, 0);
      repeat (12) @(posedge CLK);
      chk("clr_start_irq", irq_cnt - n0, 0);
      wr(O_RES, 32'd5);
      wr(O_CTRL, 32'h5);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RES = 1'b0;
      DADDR = WBASE | 32'(O_STAT); RD = 1'b1;
      #1 chk("async_rst_status", DATAI, 0);
      chk("async_rst_irq", 32'(IRQ), 0);
      RD = 1'b0; DADDR = '0;
      rd(O_RES, d); chk("async_rst_result", d, 0);
      rd(O_LEN, d); chk("async_rst_len", d, 0);
      n0 = irq_cnt;
      @(negedge CLK) RES = 1'b1;
      repeat (12) @(posedge CLK);
      chk("async_rst_no_irq", irq_cnt - n0, 0);
      rd(O_STAT, d); chk("async_rst_status_late", d, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
